// File: rtl/sha_host_ctrl.sv
// Host-side initiator for the SHA-256 core: loads message bytes, launches the core, streams back the digest.
// Optional watchdog on the ARM/WAIT handshake is enabled by defining SHA_HOST_TIMEOUT_EN.
module sha_host_ctrl #(
  parameter int unsigned OUTPUT_LENGTH      = 8,
  parameter int unsigned MAX_MESSAGE_LENGTH = 55,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [7:0]                            in_data,
  input  logic                                  in_last,
  output logic [$clog2(MAX_MESSAGE_LENGTH)-1:0] host__msg__address,
  output logic                                  host__msg__enable,
  output logic                                  host__msg__write,
  output logic [7:0]                            host__msg__data,
  output logic                                  xxx__dut__go,
  output logic [$clog2(MAX_MESSAGE_LENGTH):0]   xxx__dut__msg_length,
  input  logic                                  dut__xxx__finish,
  output logic [$clog2(OUTPUT_LENGTH)-1:0]      host__dom__address,
  output logic                                  host__dom__enable,
  output logic                                  host__dom__write,
  input  logic [31:0]                           dom__host__data,
  output logic                                  digest_valid,
  input  logic                                  digest_ready,
  output logic [31:0]                           digest_data,
  output logic                                  digest_last,
  output logic                                  err_overflow,
  output logic                                  err_timeout
);

  localparam int unsigned AW = $clog2(MAX_MESSAGE_LENGTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned OW = $clog2(OUTPUT_LENGTH);
  localparam logic [LW-1:0] MAX_CNT  = LW'(MAX_MESSAGE_LENGTH);
  localparam logic [OW-1:0] LAST_IDX = OW'(OUTPUT_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, GO, ARM, WAIT, RD_REQ, RD_CAP, EMIT
  } state_t;

  state_t        state, state_next;
  logic [LW-1:0] count, count_next;
  logic [OW-1:0] index, index_next;
  logic          ovf_next;
  logic          ready_c;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcount, tcount_next;
  logic          tmo_next;
`endif

  // The memory write port is combinational so a byte lands in the cycle it is accepted.
  assign in_ready           = ready_c && !reset;
  assign host__msg__enable  = wr_en && !reset;
  assign host__msg__write   = host__msg__enable;
  assign host__msg__address = host__msg__enable ? wr_addr : '0;
  assign host__msg__data    = host__msg__enable ? in_data : 8'h00;
  assign host__dom__write   = 1'b0;

  // Next-state, counters and memory write decode.
  always_comb begin
    state_next = state;
    count_next = count;
    index_next = index;
    ovf_next   = err_overflow;
    ready_c    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
`ifdef SHA_HOST_TIMEOUT_EN
    tcount_next = tcount;
    tmo_next    = err_timeout;
`endif
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (in_valid) begin
          wr_en      = 1'b1;
          count_next = LW'(1);
          ovf_next   = 1'b0;
          state_next = in_last ? GO : LOAD;
        end
      end
      LOAD: begin
        ready_c = 1'b1;
        if (in_valid) begin
          // Bytes past the memory depth are swallowed so the producer never stalls.
          if (count < MAX_CNT) begin
            wr_en      = 1'b1;
            wr_addr    = count[AW-1:0];
            count_next = count + LW'(1);
          end else begin
            ovf_next = 1'b1;
          end
          if (in_last) state_next = GO;
        end
      end
      GO:     state_next = ARM;
      ARM:    if (!dut__xxx__finish) state_next = WAIT;
      WAIT: begin
        if (dut__xxx__finish) begin
          state_next = RD_REQ;
          index_next = '0;
        end
      end
      RD_REQ: state_next = RD_CAP;
      RD_CAP: state_next = EMIT;
      EMIT: begin
        if (digest_ready) begin
          if (index == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            index_next = index + OW'(1);
            state_next = RD_REQ;
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef SHA_HOST_TIMEOUT_EN
    // Watchdog spans ARM and WAIT together; a normal exit on the last cycle still wins.
    if (state == IDLE && in_valid) tmo_next = 1'b0;
    if (state == GO) begin
      tcount_next = '0;
    end else if (state == ARM || state == WAIT) begin
      if (tcount == TW'(TIMEOUT_CYCLES - 1) && state_next != RD_REQ) begin
        state_next = IDLE;
        tmo_next   = 1'b1;
      end else begin
        tcount_next = tcount + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered datapath and outputs, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      count                <= '0;
      index                <= '0;
      err_overflow         <= 1'b0;
      xxx__dut__go         <= 1'b0;
      xxx__dut__msg_length <= '0;
      host__dom__enable    <= 1'b0;
      host__dom__address   <= '0;
      digest_valid         <= 1'b0;
      digest_last          <= 1'b0;
      digest_data          <= '0;
    end else begin
      count             <= count_next;
      index             <= index_next;
      err_overflow      <= ovf_next;
      xxx__dut__go      <= (state_next == GO);
      if (state_next == GO) xxx__dut__msg_length <= count_next;
      host__dom__enable <= (state_next == RD_REQ);
      if (state_next == RD_REQ) host__dom__address <= index_next;
      if (state == RD_CAP) digest_data <= dom__host__data;
      digest_valid      <= (state_next == EMIT);
      digest_last       <= (state_next == EMIT) && (index_next == LAST_IDX);
    end
  end

`ifdef SHA_HOST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount      <= '0;
      err_timeout <= 1'b0;
    end else begin
      tcount      <= tcount_next;
      err_timeout <= tmo_next;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_sha_host_ctrl.sv
// Scoreboard bench for sha_host_ctrl with a behavioural SHA core (finish handshake + output memory).
module tb_sha_host_ctrl;

  localparam int ML = 55;
  localparam int OL = 8;
`ifdef SHA_HOST_TIMEOUT_EN
  localparam int unsigned TO = 16;
  localparam int RISE_LONG = 10;
`else
  localparam int unsigned TO = 4096;
  localparam int RISE_LONG = 100;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic [5:0]  host__msg__address;
  logic        host__msg__enable, host__msg__write;
  logic [7:0]  host__msg__data;
  logic        xxx__dut__go;
  logic [6:0]  xxx__dut__msg_length;
  logic        dut__xxx__finish;
  logic [2:0]  host__dom__address;
  logic        host__dom__enable, host__dom__write;
  logic [31:0] dom__host__data;
  logic        digest_valid, digest_ready, digest_last;
  logic [31:0] digest_data;
  logic        err_overflow, err_timeout;

  sha_host_ctrl #(.OUTPUT_LENGTH(OL), .MAX_MESSAGE_LENGTH(ML), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .host__msg__address(host__msg__address), .host__msg__enable(host__msg__enable),
    .host__msg__write(host__msg__write), .host__msg__data(host__msg__data),
    .xxx__dut__go(xxx__dut__go), .xxx__dut__msg_length(xxx__dut__msg_length),
    .dut__xxx__finish(dut__xxx__finish),
    .host__dom__address(host__dom__address), .host__dom__enable(host__dom__enable),
    .host__dom__write(host__dom__write), .dom__host__data(dom__host__data),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest_data(digest_data),
    .digest_last(digest_last), .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [13:0] exp_wr[$];
  logic [6:0]  exp_len[$];
  logic [32:0] exp_dig[$];

  logic [31:0] dom_mem[8];
  logic [31:0] abc_dig[8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                              32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  int drop_dly  = 1;
  int rise_dly  = 5;
  bit hang      = 1'b0;
  bit core_done;
  int ready_mode = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: output presented with nothing expected (t=%0t)", name, $time);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: finish drops drop_dly cycles after go, rises rise_dly later (or never while hang).
  initial begin
    dut__xxx__finish = 1'b1;
    core_done        = 1'b1;
    forever begin
      @(negedge clk);
      if (xxx__dut__go && !reset) begin
        core_done = 1'b0;
        repeat (drop_dly) @(negedge clk);
        dut__xxx__finish = 1'b0;
        if (hang) wait (!hang);
        else repeat (rise_dly) @(negedge clk);
        dut__xxx__finish = 1'b1;
        core_done        = 1'b1;
      end
    end
  end

  always @(posedge clk) if (host__dom__enable) dom__host__data <= dom_mem[host__dom__address];

  initial begin
    digest_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       digest_ready = 1'b1;
        1:       digest_ready = 1'($urandom_range(0, 1));
        default: digest_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a write, a go, a read or a digest word.
  logic [13:0] e_wr;
  logic [32:0] e_dig;
  logic [6:0]  cur_len;
  logic [31:0] stall_data;
  bit          stall_pending = 1'b0;
  int          words_in_msg = 0;
  int          last_hs_cyc = 0;
  always @(negedge clk) begin
    if (reset) begin
      stall_pending = 1'b0;
      words_in_msg  = 0;
    end else begin
      if (host__msg__enable) begin
        if (exp_wr.size() == 0) unexpected("msg_write");
        else begin
          e_wr = exp_wr.pop_front();
          check("msg_write", {host__msg__write, host__msg__address, host__msg__data}, {1'b1, e_wr});
        end
      end
      if (xxx__dut__go) begin
        if (exp_len.size() == 0) unexpected("go");
        else begin
          cur_len = exp_len.pop_front();
          check("go_msg_length", xxx__dut__msg_length, cur_len);
        end
      end
      if (host__dom__enable) begin
        check("dom_read_after_finish", core_done, 1);
        check("dom_write_low", host__dom__write, 0);
      end
      if (digest_valid) begin
        check("msg_length_hold", xxx__dut__msg_length, cur_len);
        if (stall_pending) check("digest_stable", digest_data, stall_data);
        if (digest_ready) begin
          stall_pending = 1'b0;
          if (exp_dig.size() == 0) unexpected("digest");
          else begin
            e_dig = exp_dig.pop_front();
            check("digest_word", {digest_last, digest_data}, e_dig);
            if (ready_mode == 0 && words_in_msg > 0) check("digest_spacing", cyc - last_hs_cyc, 3);
            last_hs_cyc  = cyc;
            words_in_msg = e_dig[32] ? 0 : words_in_msg + 1;
          end
        end else begin
          stall_pending = 1'b1;
          stall_data    = digest_data;
        end
      end
    end
  end

  task automatic send_bytes(input bq_t msg, input bit with_last);
    int t;
    for (int i = 0; i < msg.size(); i++) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = with_last && (i == msg.size() - 1);
      if (i < ML) exp_wr.push_back({6'(i), msg[i]});
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 64) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) unexpected("in_ready_wait_expired");
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_digests();
    int t = 0;
    while (exp_dig.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("digest_all_delivered", exp_dig.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input bq_t msg, input logic [31:0] w[8], input bit wait_done);
    for (int i = 0; i < OL; i++) begin
      dom_mem[i] = w[i];
      exp_dig.push_back({(i == OL - 1), w[i]});
    end
    exp_len.push_back(7'((msg.size() > ML) ? ML : msg.size()));
    send_bytes(msg, 1'b1);
    @(negedge clk);
    check("go_cycle_in_ready_low", in_ready, 0);
    check("err_overflow", err_overflow, (msg.size() > ML) ? 1 : 0);
    if (wait_done) wait_digests();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_msg_port"}, {host__msg__enable, host__msg__write, host__msg__address, host__msg__data}, 0);
    check({tag, "_ctrl"}, {xxx__dut__go, xxx__dut__msg_length}, 0);
    check({tag, "_dom"}, {host__dom__enable, host__dom__write, host__dom__address}, 0);
    check({tag, "_digest"}, {digest_valid, digest_last, digest_data}, 0);
    check({tag, "_err"}, {err_overflow, err_timeout}, 0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals(tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  bq_t         abc;
  bq_t         m;
  logic [31:0] w[8];
  int          t;

  initial begin
    abc = '{8'h61, 8'h62, 8'h63};
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset("reset");

    // "abc" with the standard digest
    run_msg(abc, abc_dig, 1'b1);

    // exactly full memory
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'(i) ^ 8'h5a);
    for (int i = 0; i < OL; i++) w[i] = 32'h0123_4567 + 32'(i) * 32'h1111_1111;
    run_msg(m, w, 1'b1);

    // overflow: 60 bytes, only 55 stored
    m = {};
    for (int i = 0; i < 60; i++) m.push_back(8'h80 + 8'(i));
    for (int i = 0; i < OL; i++) w[i] = 32'hdead_0000 | 32'(i);
    run_msg(m, w, 1'b1);

    // stale finish held through go, long busy period
    drop_dly = 2;
    rise_dly = RISE_LONG;
    run_msg(abc, abc_dig, 1'b1);
    check("err_timeout_idle", err_timeout, 0);
    drop_dly = 1;
    rise_dly = 5;

    // random back-pressure on the digest stream
    ready_mode = 1;
    m = {};
    for (int i = 0; i < 8; i++) m.push_back(8'h10 + 8'(i));
    for (int i = 0; i < OL; i++) w[i] = 32'hc0de_0000 + 32'(i) * 32'h0001_0203;
    run_msg(m, w, 1'b1);
    ready_mode = 0;

    // reset in the middle of LOAD
    m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(m, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hee;
    pulse_reset("rst_load");
    run_msg(abc, abc_dig, 1'b1);

    // reset while a digest word is stalled in EMIT
    ready_mode = 2;
    run_msg(abc, abc_dig, 1'b0);
    t = 0;
    while (!digest_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("emit_reached", digest_valid, 1);
    @(posedge clk);
    #1;
    pulse_reset("rst_emit");
    exp_dig.delete();
    ready_mode = 0;
    run_msg(abc, abc_dig, 1'b1);

`ifdef SHA_HOST_TIMEOUT_EN
    // finish never rises: watchdog must return to IDLE with no digest
    hang = 1'b1;
    exp_len.push_back(7'd3);
    send_bytes(abc, 1'b1);
    @(negedge clk);
    t = 0;
    while (!err_timeout && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("timeout_latency", t, 17);
    check("timeout_in_ready", in_ready, 1);
    check("timeout_no_digest", digest_valid, 0);
    hang = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_msg(abc, abc_dig, 1'b0);
    check("timeout_cleared", err_timeout, 0);
    wait_digests();
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queues_drained", {exp_wr.size() == 0, exp_len.size() == 0, exp_dig.size() == 0}, 3'b111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
